match_controller: RTL and testbench
===================================

MATCH_CONTROLLER -- requirements
Module: match_controller

Interface
REQ-001 Parameter VRES, default 720, vertical active lines.
REQ-002 Parameter PADDLE_H, default 20, paddle height in lines.
REQ-003 Parameter WIN_SCORE, default 7, points needed to win; range 1..15.
REQ-004 Parameter SERVE_FRAMES, default 60, frames held before each serve; range 1..255.
REQ-005 Parameter GAMEOVER_FRAMES, default 128, frames the game-over screen is held; range 1..255.
REQ-006 Port pixel_clk  in  1  sole clock; all logic SHALL be clocked on its rising edge.
REQ-007 Port rst  in  1  reset, synchronous and active-high.
REQ-008 Port fsync  in  1  one-cycle frame-start pulse.
REQ-009 Port vpos  in  12 (signed)  current line.
REQ-010 Port active_obj  in  1  ball covers current pixel.
REQ-011 Port active_paddle_p1 / active_paddle_p2  in  1 each  bottom / top paddle covers current pixel.
REQ-012 Port obj_rst  out  1  holds ball in serve position while high.
REQ-013 Port pad_rst  out  1  recentres both paddles while high.
REQ-014 Port score_p1 / score_p2  out  4 each  current scores.
REQ-015 Port inc_p1 / inc_p2  out  1 each  one-cycle pulse per point awarded.
REQ-016 Port game_over  out  1  game-over screen request.
REQ-017 Port winner  out  1  0 = P1, 1 = P2; valid while game_over is high.
REQ-018 Port state  out  2  SERVE=0, PLAY=1, POINT=2, OVER=3.

Function
REQ-019 Bottom row = line VRES-PADDLE_H (P1 guards it); top row = line PADDLE_H-1 (P2 guards it).
REQ-020 Per-frame flags in PLAY: touch_b/touch_t set on any cycle with active_obj on the bottom/top row; hit_b/hit_t set on any cycle with active_obj plus active_paddle_p1/p2 on that row; all four flags clear on each fsync after being evaluated.
REQ-021 Evaluation on fsync in PLAY: miss_b = touch_b & ~hit_b; miss_t = touch_t & ~hit_t.
REQ-022 miss_b only: score_p2 increments and inc_p2 pulses on the cycle after the fsync; symmetric for miss_t to P1.
REQ-023 miss_b and miss_t in the same frame: no point is awarded and the FSM moves to POINT.
REQ-024 Scores SHALL saturate at WIN_SCORE and never wrap.
REQ-025 SERVE: obj_rst=1, pad_rst=1; frame counter counts fsyncs; after SERVE_FRAMES fsyncs, move to PLAY with counter cleared.
REQ-026 PLAY: obj_rst=0, pad_rst=0; any miss moves to POINT on the evaluating fsync.
REQ-027 POINT: obj_rst=1, pad_rst=0, held exactly 1 cycle.
REQ-028 From POINT, if either score equals WIN_SCORE, move to OVER and latch winner; otherwise move to SERVE.
REQ-029 OVER: game_over=1, obj_rst=1, pad_rst=1.
REQ-030 After GAMEOVER_FRAMES fsyncs in OVER, clear both scores and winner, deassert game_over, and enter SERVE.
REQ-031 fsync arriving in the same cycle as a PLAY-to-POINT transition SHALL count only as the evaluation, never also as a SERVE frame.
REQ-032 All outputs SHALL be registered; latency from the evaluating fsync to the inc pulse and score update is 1 cycle.

Reset
REQ-033 rst SHALL override all other inputs in any state, mid-frame included.
REQ-034 Reset values: state=SERVE, counter=0, all per-frame flags=0, scores=0, inc_p1=inc_p2=0, game_over=0, winner=0, obj_rst=1, pad_rst=1.

Verification
REQ-035 rst, then 60 fsyncs -> state=PLAY on the cycle after the 60th fsync; obj_rst falls to 0 at that point.
REQ-036 PLAY, active_obj on line 700 with active_paddle_p1=0, then fsync -> inc_p2 pulses once and score_p2=1; state goes POINT then SERVE.
REQ-037 PLAY, active_obj and active_paddle_p1 together on line 700, then fsync -> no inc pulse, scores unchanged, state stays PLAY.
REQ-038 Both rows missed in one frame -> scores unchanged, no inc pulse, state returns to SERVE.
REQ-039 score_p1=6, then a top miss -> score_p1=7, game_over=1, winner=0 for 128 frames, then scores=0 and state=SERVE.
REQ-040 rst asserted mid-PLAY with score 3-2 -> next cycle scores=0, state=SERVE, game_over=0.

Source files
------------

// File: rtl/match_controller_if.sv
// Signal bundle between the raster/video side and the match controller.
interface match_controller_if;
  logic               fsync;
  logic signed [11:0] vpos;
  logic               active_obj;
  logic               active_paddle_p1;
  logic               active_paddle_p2;
  logic               obj_rst;
  logic               pad_rst;
  logic [3:0]         score_p1;
  logic [3:0]         score_p2;
  logic               inc_p1;
  logic               inc_p2;
  logic               game_over;
  logic               winner;
  logic [1:0]         state;

  modport slave (
    input  fsync, vpos, active_obj, active_paddle_p1, active_paddle_p2,
    output obj_rst, pad_rst, score_p1, score_p2, inc_p1, inc_p2,
           game_over, winner, state
  );

  modport master (
    output fsync, vpos, active_obj, active_paddle_p1, active_paddle_p2,
    input  obj_rst, pad_rst, score_p1, score_p2, inc_p1, inc_p2,
           game_over, winner, state
  );
endinterface

// File: rtl/match_controller.sv
// Pong match sequencer: serve hold, per-frame miss detection on the paddle rows,
// scoring with saturation and a timed game-over screen.
module match_controller #(
  parameter int VRES            = 720,
  parameter int PADDLE_H        = 20,
  parameter int WIN_SCORE       = 7,
  parameter int SERVE_FRAMES    = 60,
  parameter int GAMEOVER_FRAMES = 128
) (
  input  logic pixel_clk,
  input  logic rst,
  match_controller_if.slave bus
);
  typedef enum logic [1:0] {SERVE = 2'd0, PLAY = 2'd1, POINT = 2'd2, OVER = 2'd3} state_t;

  localparam logic signed [11:0] ROW_B = 12'(VRES - PADDLE_H);
  localparam logic signed [11:0] ROW_T = 12'(PADDLE_H - 1);
  localparam logic [3:0]         WIN   = 4'(WIN_SCORE);

  state_t     st, st_nx;
  logic [7:0] cnt, cnt_nx;
  logic [3:0] score1, score2, s1_nx, s2_nx;
  logic       inc1, inc2, inc1_nx, inc2_nx;
  logic       win, win_nx;
  logic       gover, obj_r, pad_r;
  logic       touch_b, touch_t, hit_b, hit_t;
  logic       on_b, on_t, miss_b, miss_t;

  assign on_b   = (bus.vpos == ROW_B);
  assign on_t   = (bus.vpos == ROW_T);
  assign miss_b = touch_b & ~hit_b;
  assign miss_t = touch_t & ~hit_t;

  // Row flags accumulate over a frame and are consumed by the fsync that ends it.
  always_ff @(posedge pixel_clk) begin
    if (rst || bus.fsync) begin
      touch_b <= 1'b0;
      touch_t <= 1'b0;
      hit_b   <= 1'b0;
      hit_t   <= 1'b0;
    end else if (st == PLAY) begin
      touch_b <= touch_b | (bus.active_obj & on_b);
      touch_t <= touch_t | (bus.active_obj & on_t);
      hit_b   <= hit_b   | (bus.active_obj & bus.active_paddle_p1 & on_b);
      hit_t   <= hit_t   | (bus.active_obj & bus.active_paddle_p2 & on_t);
    end
  end

  always_comb begin
    st_nx   = st;
    cnt_nx  = cnt;
    s1_nx   = score1;
    s2_nx   = score2;
    inc1_nx = 1'b0;
    inc2_nx = 1'b0;
    win_nx  = win;
    case (st)
      SERVE: if (bus.fsync) begin
        if (cnt == 8'(SERVE_FRAMES - 1)) begin
          st_nx  = PLAY;
          cnt_nx = '0;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      PLAY: if (bus.fsync && (miss_b || miss_t)) begin
        st_nx  = POINT;
        cnt_nx = '0;
        // A double miss is a dead ball: nobody scores.
        if (miss_b && !miss_t) begin
          inc2_nx = 1'b1;
          if (score2 < WIN) s2_nx = score2 + 4'd1;
        end
        if (miss_t && !miss_b) begin
          inc1_nx = 1'b1;
          if (score1 < WIN) s1_nx = score1 + 4'd1;
        end
      end
      POINT: begin
        cnt_nx = '0;
        if (score1 == WIN || score2 == WIN) begin
          st_nx  = OVER;
          win_nx = (score2 == WIN);
        end else begin
          st_nx = SERVE;
        end
      end
      OVER: if (bus.fsync) begin
        if (cnt == 8'(GAMEOVER_FRAMES - 1)) begin
          st_nx  = SERVE;
          cnt_nx = '0;
          s1_nx  = '0;
          s2_nx  = '0;
          win_nx = 1'b0;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      default: st_nx = SERVE;
    endcase
  end

  // Status outputs are derived from the next state so they line up with it.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      st     <= SERVE;
      cnt    <= '0;
      score1 <= '0;
      score2 <= '0;
      inc1   <= 1'b0;
      inc2   <= 1'b0;
      win    <= 1'b0;
      gover  <= 1'b0;
      obj_r  <= 1'b1;
      pad_r  <= 1'b1;
    end else begin
      st     <= st_nx;
      cnt    <= cnt_nx;
      score1 <= s1_nx;
      score2 <= s2_nx;
      inc1   <= inc1_nx;
      inc2   <= inc2_nx;
      win    <= win_nx;
      gover  <= (st_nx == OVER);
      obj_r  <= (st_nx != PLAY);
      pad_r  <= (st_nx == SERVE) || (st_nx == OVER);
    end
  end

  assign bus.state     = st;
  assign bus.score_p1  = score1;
  assign bus.score_p2  = score2;
  assign bus.inc_p1    = inc1;
  assign bus.inc_p2    = inc2;
  assign bus.winner    = win;
  assign bus.game_over = gover;
  assign bus.obj_rst   = obj_r;
  assign bus.pad_rst   = pad_r;
endmodule

// File: tb/tb_match_controller.sv
// Directed bench for match_controller at default parameters.
module tb_match_controller;
  logic pixel_clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 pixel_clk = ~pixel_clk;

  match_controller_if bus();

  match_controller dut (
    .pixel_clk (pixel_clk),
    .rst       (rst),
    .bus       (bus)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One pixel cycle with the given line and coverage; drive and sample on negedge.
  task automatic pix(input int v, input logic o, input logic p1, input logic p2);
    bus.vpos             = 12'(v);
    bus.active_obj       = o;
    bus.active_paddle_p1 = p1;
    bus.active_paddle_p2 = p2;
    @(negedge pixel_clk);
    bus.active_obj       = 1'b0;
    bus.active_paddle_p1 = 1'b0;
    bus.active_paddle_p2 = 1'b0;
    bus.vpos             = 12'sd0;
  endtask

  task automatic fs();
    bus.fsync = 1'b1;
    @(negedge pixel_clk);
    bus.fsync = 1'b0;
  endtask

  task automatic serve();
    for (int i = 0; i < 59; i++) begin
      fs();
      pix(0, 1'b0, 1'b0, 1'b0);
    end
    chk("serve_hold_59", 16'(bus.state), 16'd0);
    chk("serve_obj_rst", 16'(bus.obj_rst), 16'd1);
    fs();
    chk("serve_to_play", 16'(bus.state), 16'd1);
    chk("play_obj_rst", 16'(bus.obj_rst), 16'd0);
    chk("play_pad_rst", 16'(bus.pad_rst), 16'd0);
  endtask

  // Full point: serve, ball crosses one row without a paddle, then POINT resolves.
  task automatic lose(input logic top);
    serve();
    pix(top ? 19 : 700, 1'b1, 1'b0, 1'b0);
    fs();
    pix(0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.fsync = 1'b0; bus.vpos = '0; bus.active_obj = 1'b0;
    bus.active_paddle_p1 = 1'b0; bus.active_paddle_p2 = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge pixel_clk);
    rst = 1'b0;
    chk("rst_state", 16'(bus.state), 16'd0);
    chk("rst_obj_rst", 16'(bus.obj_rst), 16'd1);
    chk("rst_pad_rst", 16'(bus.pad_rst), 16'd1);
    chk("rst_scores", {8'd0, bus.score_p1, bus.score_p2}, 16'd0);
    chk("rst_inc", {14'd0, bus.inc_p1, bus.inc_p2}, 16'd0);
    chk("rst_game_over", 16'(bus.game_over), 16'd0);
    chk("rst_winner", 16'(bus.winner), 16'd0);

    serve();
    // Bottom hit, top hit, off-row ball and paddle without ball: no point.
    pix(700, 1'b1, 1'b1, 1'b0);
    pix(19, 1'b1, 1'b0, 1'b1);
    pix(701, 1'b1, 1'b0, 1'b0);
    pix(18, 1'b1, 1'b0, 1'b0);
    pix(700, 1'b0, 1'b1, 1'b0);
    fs();
    chk("hit_inc", {14'd0, bus.inc_p1, bus.inc_p2}, 16'd0);
    chk("hit_state", 16'(bus.state), 16'd1);
    chk("hit_scores", {8'd0, bus.score_p1, bus.score_p2}, 16'd0);

    // Bottom miss: P2 scores.
    pix(700, 1'b1, 1'b0, 1'b0);
    fs();
    chk("missb_inc_p2", 16'(bus.inc_p2), 16'd1);
    chk("missb_inc_p1", 16'(bus.inc_p1), 16'd0);
    chk("missb_score_p2", 16'(bus.score_p2), 16'd1);
    chk("missb_state", 16'(bus.state), 16'd2);
    chk("point_obj_rst", 16'(bus.obj_rst), 16'd1);
    chk("point_pad_rst", 16'(bus.pad_rst), 16'd0);
    pix(0, 1'b0, 1'b0, 1'b0);
    chk("missb_inc_off", 16'(bus.inc_p2), 16'd0);
    chk("missb_serve", 16'(bus.state), 16'd0);
    chk("serve_pad_rst", 16'(bus.pad_rst), 16'd1);

    // Double miss: dead ball.
    serve();
    pix(700, 1'b1, 1'b0, 1'b0);
    pix(19, 1'b1, 1'b0, 1'b0);
    fs();
    chk("dbl_inc", {14'd0, bus.inc_p1, bus.inc_p2}, 16'd0);
    chk("dbl_state", 16'(bus.state), 16'd2);
    chk("dbl_scores", {8'd0, bus.score_p1, bus.score_p2}, 16'h0001);
    pix(0, 1'b0, 1'b0, 1'b0);
    chk("dbl_serve", 16'(bus.state), 16'd0);

    // P1 to 6, then the winning point.
    for (int i = 0; i < 6; i++) lose(1'b1);
    chk("p1_six", {8'd0, bus.score_p1, bus.score_p2}, 16'h0061);
    serve();
    pix(19, 1'b1, 1'b0, 1'b0);
    fs();
    chk("p1_win_inc", 16'(bus.inc_p1), 16'd1);
    chk("p1_win_score", 16'(bus.score_p1), 16'd7);
    pix(0, 1'b0, 1'b0, 1'b0);
    chk("over_state", 16'(bus.state), 16'd3);
    chk("over_game_over", 16'(bus.game_over), 16'd1);
    chk("over_winner", 16'(bus.winner), 16'd0);
    chk("over_rsts", {14'd0, bus.obj_rst, bus.pad_rst}, 16'd3);
    for (int i = 0; i < 127; i++) begin
      fs();
      pix(0, 1'b0, 1'b0, 1'b0);
    end
    chk("over_hold_127", 16'(bus.game_over), 16'd1);
    chk("over_score_hold", 16'(bus.score_p1), 16'd7);
    fs();
    chk("over_exit_state", 16'(bus.state), 16'd0);
    chk("over_exit_scores", {8'd0, bus.score_p1, bus.score_p2}, 16'd0);
    chk("over_exit_go", 16'(bus.game_over), 16'd0);

    // 3-2, then reset in the middle of play.
    for (int i = 0; i < 3; i++) lose(1'b1);
    for (int i = 0; i < 2; i++) lose(1'b0);
    chk("score_3_2", {8'd0, bus.score_p1, bus.score_p2}, 16'h0032);
    serve();
    pix(300, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    pix(700, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    chk("midrst_scores", {8'd0, bus.score_p1, bus.score_p2}, 16'd0);
    chk("midrst_state", 16'(bus.state), 16'd0);
    chk("midrst_go", 16'(bus.game_over), 16'd0);
    chk("midrst_obj_rst", 16'(bus.obj_rst), 16'd1);

    // P2 wins 7-0.
    for (int i = 0; i < 6; i++) lose(1'b0);
    serve();
    pix(700, 1'b1, 1'b0, 1'b0);
    fs();
    chk("p2_win_score", 16'(bus.score_p2), 16'd7);
    pix(0, 1'b0, 1'b0, 1'b0);
    chk("p2_over_state", 16'(bus.state), 16'd3);
    chk("p2_winner", 16'(bus.winner), 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
